// File: rtl/apb_bridge_pkg.sv
// Shared definitions for the AHB-to-APB bridge: FSM state encoding,
// slave count, PSEL decode bit positions and default bus widths.
package apb_bridge_pkg;

    localparam int APB_NUM_SLAVES = 4;
    localparam int PSEL_MSB       = 25;
    localparam int PSEL_LSB       = 24;
    localparam int APB_ADDR_W_DEF = 32;
    localparam int APB_DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    // Turn the two slave-select address bits into a one-hot PSEL vector.
    function automatic logic [APB_NUM_SLAVES-1:0] psel_decode(
        input logic [PSEL_MSB-PSEL_LSB:0] sel
    );
        logic [APB_NUM_SLAVES-1:0] onehot;
        onehot      = '0;
        onehot[sel] = 1'b1;
        return onehot;
    endfunction

endpackage

// File: rtl/apb_req_buffer.sv
// One-entry holding buffer for an AHB request that arrives while the APB
// side is still busy with the previous transfer.
module apb_req_buffer
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W_DEF,
    parameter int DATA_W = APB_DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              drain,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_write,
    output logic              full,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              write
);

    // Occupancy flag; load and drain never coincide because a full buffer
    // blocks new acceptances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

    // Payload is only meaningful while full is set, so it carries no reset.
    always_ff @(posedge clk) begin
        if (load) begin
            addr  <= load_addr;
            data  <= load_data;
            write <= load_write;
        end
    end

endmodule

// File: rtl/apb_controller.sv
// APB master side of the AHB-to-APB bridge. Converts latched AHB requests
// into SETUP/ACCESS APB transfers, holds one extra request in a pending
// buffer and stalls the AHB side while a read is outstanding.
// Optional build macro: APB_CTRL_WAIT_STATE_EN -- when defined ACCESS waits
// for PREADY; when undefined PREADY is ignored and ACCESS lasts one cycle.
module apb_controller
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W_DEF,
    parameter int DATA_W = APB_DATA_W_DEF
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic                      VALID,
    input  logic [ADDR_W-1:0]         HADDR_TEMP,
    input  logic [DATA_W-1:0]         HWDATA_TEMP,
    input  logic                      HWRITE_TEMP,
    input  logic [DATA_W-1:0]         PRDATA,
    input  logic                      PREADY,
    output logic [APB_NUM_SLAVES-1:0] PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [ADDR_W-1:0]         PADDR,
    output logic [DATA_W-1:0]         PWDATA,
    output logic                      HREADYOUT,
    output logic [DATA_W-1:0]         HRDATA
);

    apb_state_e        state, state_nxt;
    logic              accept;
    logic              access_done;
    logic              complete;
    logic              load_req;
    logic              load_pend;
    logic              buf_load;
    logic              buf_full;
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_data;
    logic              buf_write;
    logic              rd_out;

`ifdef APB_CTRL_WAIT_STATE_EN
    assign access_done = PREADY;
`else
    logic unused_pready;
    assign unused_pready = PREADY;
    assign access_done   = 1'b1;
`endif

    assign HREADYOUT = !buf_full && !rd_out;
    assign accept    = VALID && HREADYOUT;
    assign complete  = (state == ST_ACCESS) && access_done;

    apb_req_buffer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_req_buffer (
        .clk        (HCLK),
        .rst_n      (HRESETn),
        .load       (buf_load),
        .drain      (load_pend),
        .load_addr  (HADDR_TEMP),
        .load_data  (HWDATA_TEMP),
        .load_write (HWRITE_TEMP),
        .full       (buf_full),
        .addr       (buf_addr),
        .data       (buf_data),
        .write      (buf_write)
    );

    // FSM state register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and transfer sourcing: a pending entry always wins over a
    // request arriving on the completion edge, keeping request order.
    always_comb begin
        state_nxt = state;
        load_req  = 1'b0;
        load_pend = 1'b0;
        buf_load  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_SETUP;
                    load_req  = 1'b1;
                end
            end
            ST_SETUP: begin
                state_nxt = ST_ACCESS;
                buf_load  = accept;
            end
            ST_ACCESS: begin
                if (access_done) begin
                    if (buf_full) begin
                        state_nxt = ST_SETUP;
                        load_pend = 1'b1;
                    end else if (accept) begin
                        state_nxt = ST_SETUP;
                        load_req  = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    buf_load = accept;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // APB request outputs: loaded on entry to SETUP and frozen until the
    // transfer completes.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            PSEL    <= '0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PADDR   <= '0;
            PWDATA  <= '0;
        end else if (load_req) begin
            PSEL    <= psel_decode(HADDR_TEMP[PSEL_MSB:PSEL_LSB]);
            PENABLE <= 1'b0;
            PWRITE  <= HWRITE_TEMP;
            PADDR   <= HADDR_TEMP;
            PWDATA  <= HWDATA_TEMP;
        end else if (load_pend) begin
            PSEL    <= psel_decode(buf_addr[PSEL_MSB:PSEL_LSB]);
            PENABLE <= 1'b0;
            PWRITE  <= buf_write;
            PADDR   <= buf_addr;
            PWDATA  <= buf_data;
        end else if (state_nxt == ST_ACCESS) begin
            PENABLE <= 1'b1;
        end else if (state_nxt == ST_IDLE) begin
            PSEL    <= '0;
            PENABLE <= 1'b0;
        end
    end

    // Read tracking: only one read can be in flight because it blocks further
    // acceptance, so any read completion belongs to the outstanding read.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rd_out <= 1'b0;
            HRDATA <= '0;
        end else if (accept && !HWRITE_TEMP) begin
            rd_out <= 1'b1;
        end else if (complete && !PWRITE) begin
            rd_out <= 1'b0;
            HRDATA <= PRDATA;
        end
    end

endmodule

// File: tb/tb_apb_controller.sv
// Self-checking bench for apb_controller: directed scenarios plus a random
// run against a transaction-queue reference model.
module tb_apb_controller;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
`ifdef APB_CTRL_WAIT_STATE_EN
    localparam int EXP_ACCESS = 4;
`else
    localparam int EXP_ACCESS = 1;
`endif

    logic              HCLK;
    logic              HRESETn;
    logic              VALID;
    logic [ADDR_W-1:0] HADDR_TEMP;
    logic [DATA_W-1:0] HWDATA_TEMP;
    logic              HWRITE_TEMP;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic [3:0]        PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic              HREADYOUT;
    logic [DATA_W-1:0] HRDATA;

    int checks = 0;
    int errors = 0;

    apb_controller #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .VALID       (VALID),
        .HADDR_TEMP  (HADDR_TEMP),
        .HWDATA_TEMP (HWDATA_TEMP),
        .HWRITE_TEMP (HWRITE_TEMP),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .HREADYOUT   (HREADYOUT),
        .HRDATA      (HRDATA)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Reference model: queue of accepted-but-not-completed transfers. Head is
    // the transfer on the APB bus, a second entry is the pending one.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        write;
    } req_t;

    req_t        m_q[$];
    bit          m_access;
    logic [31:0] m_hrdata;

    function automatic bit m_ready();
        if (m_q.size() >= 2) return 1'b0;
        foreach (m_q[i]) if (!m_q[i].write) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [3:0] m_psel();
        logic [3:0] p;
        p = 4'b0000;
        if (m_q.size() > 0) p[m_q[0].addr[25:24]] = 1'b1;
        return p;
    endfunction

    task automatic m_reset();
        m_q.delete();
        m_access = 1'b0;
        m_hrdata = '0;
    endtask

    // Apply one rising edge to the model using the current inputs, then
    // advance the DUT clock and settle 1 time unit past the edge.
    task automatic step();
        bit   acc;
        bit   comp;
        req_t r;
        acc = VALID && m_ready();
`ifdef APB_CTRL_WAIT_STATE_EN
        comp = (m_q.size() > 0) && m_access && (PREADY === 1'b1);
`else
        comp = (m_q.size() > 0) && m_access;
`endif
        if (comp) begin
            if (!m_q[0].write) m_hrdata = PRDATA;
            void'(m_q.pop_front());
            m_access = 1'b0;
        end else if (m_q.size() > 0) begin
            m_access = 1'b1;
        end
        if (acc) begin
            r.addr  = HADDR_TEMP;
            r.data  = HWDATA_TEMP;
            r.write = HWRITE_TEMP;
            m_q.push_back(r);
            if (m_q.size() == 1) m_access = 1'b0;
        end
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive_req(input logic [31:0] a, input logic [31:0] d, input logic w);
        VALID       = 1'b1;
        HADDR_TEMP  = a;
        HWDATA_TEMP = d;
        HWRITE_TEMP = w;
    endtask

    task automatic test_reset();
        HRESETn = 1'b1;
        #2 HRESETn = 1'b0;
        #1;
        checks++;
        if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, HRDATA, HREADYOUT} !== {4'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1}) begin
            errors++;
            $display("FAIL reset_values got psel=%b en=%b wr=%b addr=%h wd=%h rd=%h rdy=%b want all zero rdy=1",
                     PSEL, PENABLE, PWRITE, PADDR, PWDATA, HRDATA, HREADYOUT);
        end
        m_reset();
        repeat (2) @(posedge HCLK);
        #1;
        checks++;
        if (PSEL !== 4'b0 || HREADYOUT !== 1'b1) begin
            errors++;
            $display("FAIL reset_held got psel=%b rdy=%b want 0000/1", PSEL, HREADYOUT);
        end
        // First acceptance at the first edge after release.
        @(negedge HCLK);
        HRESETn = 1'b1;
        drive_req(32'hA200_0000, 32'h1111_2222, 1'b1);
        step();
        VALID = 1'b0;
        checks++;
        if (PSEL !== 4'b0100 || PENABLE !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_accept got psel=%b en=%b want 0100/0", PSEL, PENABLE);
        end
        step();
        step();
        checks++;
        if (PSEL !== 4'b0) begin
            errors++;
            $display("FAIL reset_first_done got psel=%b want 0000", PSEL);
        end
    endtask

    task automatic test_single_write();
        PREADY = 1'b1;
        drive_req(32'hA000_0000, 32'h1234_5678, 1'b1);
        step();
        VALID = 1'b0;
        checks++;
        if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, HREADYOUT} !== {4'b0001, 1'b0, 1'b1, 32'hA000_0000, 32'h1234_5678, 1'b1}) begin
            errors++;
            $display("FAIL write_setup got psel=%b en=%b wr=%b addr=%h wd=%h rdy=%b want 0001/0/1/a0000000/12345678/1",
                     PSEL, PENABLE, PWRITE, PADDR, PWDATA, HREADYOUT);
        end
        step();
        checks++;
        if ({PSEL, PENABLE, PWDATA, HREADYOUT} !== {4'b0001, 1'b1, 32'h1234_5678, 1'b1}) begin
            errors++;
            $display("FAIL write_access got psel=%b en=%b wd=%h rdy=%b want 0001/1/12345678/1",
                     PSEL, PENABLE, PWDATA, HREADYOUT);
        end
        step();
        checks++;
        if ({PSEL, PENABLE, HREADYOUT} !== {4'b0000, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL write_idle got psel=%b en=%b rdy=%b want 0000/0/1", PSEL, PENABLE, HREADYOUT);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d1, d2;
        d1 = $urandom();
        d2 = $urandom();
        PREADY = 1'b1;
        drive_req(32'hA100_0004, d1, 1'b1);
        step();
        checks++;
        if ({PSEL, PENABLE, HREADYOUT} !== {4'b0010, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL b2b_first_setup got psel=%b en=%b rdy=%b want 0010/0/1", PSEL, PENABLE, HREADYOUT);
        end
        drive_req(32'hA000_0008, d2, 1'b1);
        step();
        VALID = 1'b0;
        checks++;
        if ({PSEL, PENABLE, PADDR, HREADYOUT} !== {4'b0010, 1'b1, 32'hA100_0004, 1'b0}) begin
            errors++;
            $display("FAIL b2b_pending got psel=%b en=%b addr=%h rdy=%b want 0010/1/a1000004/0",
                     PSEL, PENABLE, PADDR, HREADYOUT);
        end
        step();
        checks++;
        if ({PSEL, PENABLE, PADDR, PWDATA, HREADYOUT} !== {4'b0001, 1'b0, 32'hA000_0008, d2, 1'b1}) begin
            errors++;
            $display("FAIL b2b_second_setup got psel=%b en=%b addr=%h wd=%h rdy=%b want 0001/0/a0000008/%h/1",
                     PSEL, PENABLE, PADDR, PWDATA, HREADYOUT, d2);
        end
        step();
        checks++;
        if ({PSEL, PENABLE} !== {4'b0001, 1'b1}) begin
            errors++;
            $display("FAIL b2b_second_access got psel=%b en=%b want 0001/1", PSEL, PENABLE);
        end
        step();
        checks++;
        if (PSEL !== 4'b0000) begin
            errors++;
            $display("FAIL b2b_idle got psel=%b want 0000", PSEL);
        end
    endtask

    task automatic test_read();
        PREADY = 1'b1;
        PRDATA = 32'hDEAD_BEEF;
        drive_req(32'hA300_0010, $urandom(), 1'b0);
        step();
        VALID = 1'b0;
        checks++;
        if ({PSEL, PWRITE, PENABLE, HREADYOUT} !== {4'b1000, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL read_setup got psel=%b wr=%b en=%b rdy=%b want 1000/0/0/0", PSEL, PWRITE, PENABLE, HREADYOUT);
        end
        step();
        checks++;
        if ({PENABLE, HREADYOUT, HRDATA} !== {1'b1, 1'b0, m_hrdata}) begin
            errors++;
            $display("FAIL read_access got en=%b rdy=%b rd=%h want 1/0/%h", PENABLE, HREADYOUT, HRDATA, m_hrdata);
        end
        step();
        checks++;
        if ({HREADYOUT, HRDATA, PSEL} !== {1'b1, 32'hDEAD_BEEF, 4'b0000}) begin
            errors++;
            $display("FAIL read_done got rdy=%b rd=%h psel=%b want 1/deadbeef/0000", HREADYOUT, HRDATA, PSEL);
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] wd;
        int          acc;
        wd     = $urandom();
        acc    = 0;
        PREADY = 1'b0;
        drive_req(32'hA200_0020, wd, 1'b1);
        step();
        VALID = 1'b0;
        step();
        for (int i = 0; i < 6; i++) begin
            if (PENABLE === 1'b1) begin
                acc++;
                checks++;
                if ({PSEL, PADDR, PWRITE, PWDATA} !== {4'b0100, 32'hA200_0020, 1'b1, wd}) begin
                    errors++;
                    $display("FAIL wait_stable got psel=%b addr=%h wr=%b wd=%h want 0100/a2000020/1/%h",
                             PSEL, PADDR, PWRITE, PWDATA, wd);
                end
            end
            PREADY = (acc >= 4);
            step();
        end
        PREADY = 1'b1;
        checks++;
        if (acc !== EXP_ACCESS) begin
            errors++;
            $display("FAIL wait_access_len got %0d want %0d", acc, EXP_ACCESS);
        end
        checks++;
        if (PSEL !== 4'b0000) begin
            errors++;
            $display("FAIL wait_idle got psel=%b want 0000", PSEL);
        end
    endtask

    task automatic test_reset_mid();
        PREADY = 1'b0;
        drive_req(32'hA100_0000, $urandom(), 1'b1);
        step();
        drive_req(32'hA200_0000, $urandom(), 1'b1);
        step();
        VALID = 1'b0;
        checks++;
        if ({PENABLE, HREADYOUT} !== {1'b1, 1'b0}) begin
            errors++;
            $display("FAIL rstmid_pre got en=%b rdy=%b want 1/0", PENABLE, HREADYOUT);
        end
        #2 HRESETn = 1'b0;
        #1;
        checks++;
        if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, HRDATA, HREADYOUT} !== {4'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1}) begin
            errors++;
            $display("FAIL rstmid_values got psel=%b en=%b wr=%b addr=%h wd=%h rd=%h rdy=%b want all zero rdy=1",
                     PSEL, PENABLE, PWRITE, PADDR, PWDATA, HRDATA, HREADYOUT);
        end
        m_reset();
        #2 HRESETn = 1'b1;
        PREADY = 1'b1;
        drive_req(32'hA000_0000, 32'hCAFE_0001, 1'b1);
        step();
        VALID = 1'b0;
        checks++;
        if ({PSEL, PENABLE, PADDR} !== {4'b0001, 1'b0, 32'hA000_0000}) begin
            errors++;
            $display("FAIL rstmid_setup got psel=%b en=%b addr=%h want 0001/0/a0000000", PSEL, PENABLE, PADDR);
        end
        step();
        checks++;
        if ({PSEL, PENABLE, PWDATA} !== {4'b0001, 1'b1, 32'hCAFE_0001}) begin
            errors++;
            $display("FAIL rstmid_access got psel=%b en=%b wd=%h want 0001/1/cafe0001", PSEL, PENABLE, PWDATA);
        end
        step();
        checks++;
        if (PSEL !== 4'b0000) begin
            errors++;
            $display("FAIL rstmid_idle got psel=%b want 0000", PSEL);
        end
    endtask

    task automatic test_ready_block();
        PREADY = 1'b1;
        PRDATA = 32'h5A5A_0F0F;
        drive_req(32'hA000_0040, 32'h0, 1'b0);
        step();
        drive_req(32'hA300_0000, 32'h7777_7777, 1'b1);
        step();
        checks++;
        if ({PSEL, PENABLE, PWRITE, HREADYOUT} !== {4'b0001, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL block_access got psel=%b en=%b wr=%b rdy=%b want 0001/1/0/0", PSEL, PENABLE, PWRITE, HREADYOUT);
        end
        step();
        VALID = 1'b0;
        checks++;
        if ({PSEL, HREADYOUT, HRDATA} !== {4'b0000, 1'b1, 32'h5A5A_0F0F}) begin
            errors++;
            $display("FAIL block_done got psel=%b rdy=%b rd=%h want 0000/1/5a5a0f0f", PSEL, HREADYOUT, HRDATA);
        end
        step();
        checks++;
        if ({PSEL, PENABLE} !== {4'b0000, 1'b0}) begin
            errors++;
            $display("FAIL block_no_extra got psel=%b en=%b want 0000/0", PSEL, PENABLE);
        end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            VALID       = (cyc < 390) ? ($urandom_range(1, 0) == 1) : 1'b0;
            HADDR_TEMP  = $urandom();
            HWDATA_TEMP = $urandom();
            HWRITE_TEMP = ($urandom_range(3, 0) != 0);
            PRDATA      = $urandom();
            PREADY      = (cyc < 390) ? ($urandom_range(9, 0) < 7) : 1'b1;
            step();
            checks++;
            if (HREADYOUT !== m_ready()) begin
                errors++;
                $display("FAIL rnd_hready cyc=%0d got %b want %b", cyc, HREADYOUT, m_ready());
            end
            checks++;
            if (HRDATA !== m_hrdata) begin
                errors++;
                $display("FAIL rnd_hrdata cyc=%0d got %h want %h", cyc, HRDATA, m_hrdata);
            end
            if (m_q.size() == 0) begin
                checks++;
                if ({PSEL, PENABLE} !== {4'b0000, 1'b0}) begin
                    errors++;
                    $display("FAIL rnd_idle cyc=%0d got psel=%b en=%b want 0000/0", cyc, PSEL, PENABLE);
                end
            end else begin
                checks++;
                if ({PSEL, PENABLE, PADDR, PWRITE} !== {m_psel(), m_access, m_q[0].addr, m_q[0].write}) begin
                    errors++;
                    $display("FAIL rnd_xfer cyc=%0d got psel=%b en=%b addr=%h wr=%b want %b/%b/%h/%b",
                             cyc, PSEL, PENABLE, PADDR, PWRITE, m_psel(), m_access, m_q[0].addr, m_q[0].write);
                end
                if (m_q[0].write) begin
                    checks++;
                    if (PWDATA !== m_q[0].data) begin
                        errors++;
                        $display("FAIL rnd_pwdata cyc=%0d got %h want %h", cyc, PWDATA, m_q[0].data);
                    end
                end
            end
        end
    endtask

    initial begin
        VALID       = 1'b0;
        HADDR_TEMP  = '0;
        HWDATA_TEMP = '0;
        HWRITE_TEMP = 1'b0;
        PRDATA      = '0;
        PREADY      = 1'b1;
        m_reset();
        test_reset();
        test_single_write();
        test_back_to_back();
        test_read();
        test_wait_states();
        test_reset_mid();
        test_ready_block();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
